fifo_vc_bank: RTL and testbench

Multi-channel buffer bank for the per-virtual-channel datapath: one write port steered by a VC index and NCH independent read ports, each backed by its own circular FIFO. It sits between the traffic-class/VC classifier and the VC arbiter. Beyond plain buffering, it adds power-of-two depth generalisation, a full-depth fill counter, registered read data with a valid strobe, hysteretic per-channel `pause` flow control, and sticky, clearable error flags.

---
 rtl/fifo_vc_pkg.sv | 19 +
 rtl/fifo_vc_chan.sv | 105 ++++++++++
 rtl/fifo_vc_bank.sv | 71 +++++++
 tb/tb_fifo_vc_bank.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_vc_pkg.sv
// Shared defaults, depth legality check and status-flag bit positions for the
// per-VC FIFO bank.
package fifo_vc_pkg;

  localparam int unsigned BW_DEF    = 6;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned NCH_DEF   = 4;

  localparam int unsigned FLG_FULL   = 0;
  localparam int unsigned FLG_EMPTY  = 1;
  localparam int unsigned FLG_AFULL  = 2;
  localparam int unsigned FLG_AEMPTY = 3;
  localparam int unsigned NFLG       = 4;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_vc_chan.sv
// One virtual-channel FIFO: circular memory, fill counter, threshold flags,
// hysteretic pause and sticky overrun/underrun bits.
module fifo_vc_chan
  import fifo_vc_pkg::*;
#(
  parameter int BW    = BW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic            wr_en,
  input  logic [BW-1:0]   wr_data,
  input  logic            rd_en,
  input  logic [AW:0]     umbral_bajo,
  input  logic [AW:0]     umbral_alto,
  input  logic            err_clr,
  output logic [BW-1:0]   rd_data,
  output logic            rd_valid,
  output logic [AW:0]     fill,
  output logic [NFLG-1:0] flags,
  output logic            pause,
  output logic            err_overrun,
  output logic            err_underrun
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [BW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [BW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          pause_q, pause_d;
  logic          ovr_q, ovr_d;
  logic          unr_q, unr_d;
  logic          full_w, empty_w, wr_ok, rd_ok;

  assign full_w  = (fill_q == DEPTH_V);
  assign empty_w = (fill_q == '0);

  always_comb begin
    // A read on a full channel frees the slot the same-cycle write lands in.
    wr_ok      = wr_en && (!full_w || rd_en);
    rd_ok      = rd_en && !empty_w;
    wr_ptr_d   = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    rd_data_d  = rd_ok ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid_d = rd_ok;
    fill_d     = fill_q;
    case ({wr_ok, rd_ok})
      2'b10:   fill_d = fill_q + (AW+1)'(1);
      2'b01:   fill_d = fill_q - (AW+1)'(1);
      default: fill_d = fill_q;
    endcase
    pause_d = pause_q;
    if (fill_d >= umbral_alto)      pause_d = 1'b1;
    else if (fill_d <= umbral_bajo) pause_d = 1'b0;
    ovr_d = (ovr_q && !err_clr) || (wr_en && !wr_ok);
    unr_d = (unr_q && !err_clr) || (rd_en && !rd_ok);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      pause_q    <= 1'b0;
      ovr_q      <= 1'b0;
      unr_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      pause_q    <= pause_d;
      ovr_q      <= ovr_d;
      unr_q      <= unr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    flags             = '0;
    flags[FLG_FULL]   = full_w;
    flags[FLG_EMPTY]  = empty_w;
    flags[FLG_AFULL]  = (fill_q >= umbral_alto);
    flags[FLG_AEMPTY] = (fill_q <= umbral_bajo);
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign fill         = fill_q;
  assign pause        = pause_q;
  assign err_overrun  = ovr_q;
  assign err_underrun = unr_q;

endmodule

// File: rtl/fifo_vc_bank.sv
// Bank of NCH independent VC FIFOs sharing one write port steered by wr_vc,
// with per-channel read ports and a combined sticky error output.
module fifo_vc_bank
  import fifo_vc_pkg::*;
#(
  parameter int BW    = BW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NCH   = NCH_DEF,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  wr_en,
  input  logic [CW-1:0]         wr_vc,
  input  logic [BW-1:0]         wr_data,
  input  logic [NCH-1:0]        rd_en,
  input  logic [AW:0]           umbral_bajo,
  input  logic [AW:0]           umbral_alto,
  input  logic                  err_clr,
  output logic [NCH*BW-1:0]     rd_data,
  output logic [NCH-1:0]        rd_valid,
  output logic [NCH*(AW+1)-1:0] fill,
  output logic [NCH-1:0]        full,
  output logic [NCH-1:0]        empty,
  output logic [NCH-1:0]        almost_full,
  output logic [NCH-1:0]        almost_empty,
  output logic [NCH-1:0]        pause,
  output logic [NCH-1:0]        err_overrun,
  output logic [NCH-1:0]        err_underrun,
  output logic                  error_output
);

  if (!is_pow2(DEPTH) || DEPTH < 2 || NCH < 2) begin : g_bad_cfg
    $error("fifo_vc_bank: DEPTH must be a power of two >= 2 and NCH >= 2");
  end

  logic [NFLG-1:0] flags_w [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    fifo_vc_chan #(
      .BW    (BW),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_chan (
      .clk          (clk),
      .reset_L      (reset_L),
      .wr_en        (wr_en && (wr_vc == CW'(i))),
      .wr_data      (wr_data),
      .rd_en        (rd_en[i]),
      .umbral_bajo  (umbral_bajo),
      .umbral_alto  (umbral_alto),
      .err_clr      (err_clr),
      .rd_data      (rd_data[i*BW +: BW]),
      .rd_valid     (rd_valid[i]),
      .fill         (fill[i*(AW+1) +: (AW+1)]),
      .flags        (flags_w[i]),
      .pause        (pause[i]),
      .err_overrun  (err_overrun[i]),
      .err_underrun (err_underrun[i])
    );

    assign full[i]         = flags_w[i][FLG_FULL];
    assign empty[i]        = flags_w[i][FLG_EMPTY];
    assign almost_full[i]  = flags_w[i][FLG_AFULL];
    assign almost_empty[i] = flags_w[i][FLG_AEMPTY];
  end

  assign error_output = |{err_overrun, err_underrun};

endmodule

// File: tb/tb_fifo_vc_bank.sv
// Directed-vector bench for fifo_vc_bank (BW=6, DEPTH=8, NCH=4, thresholds 2/6).
module tb_fifo_vc_bank;

  localparam int BW = 6, DEPTH = 8, NCH = 4, AW = 3, CW = 2;

  logic                  clk = 1'b0;
  logic                  reset_L;
  logic                  wr_en;
  logic [CW-1:0]         wr_vc;
  logic [BW-1:0]         wr_data;
  logic [NCH-1:0]        rd_en;
  logic [AW:0]           umbral_bajo, umbral_alto;
  logic                  err_clr;
  logic [NCH*BW-1:0]     rd_data;
  logic [NCH-1:0]        rd_valid;
  logic [NCH*(AW+1)-1:0] fill;
  logic [NCH-1:0]        full, empty, almost_full, almost_empty, pause;
  logic [NCH-1:0]        err_overrun, err_underrun;
  logic                  error_output;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  fifo_vc_bank #(
    .BW    (BW),
    .DEPTH (DEPTH),
    .NCH   (NCH)
  ) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .wr_en        (wr_en),
    .wr_vc        (wr_vc),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .umbral_bajo  (umbral_bajo),
    .umbral_alto  (umbral_alto),
    .err_clr      (err_clr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .fill         (fill),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .pause        (pause),
    .err_overrun  (err_overrun),
    .err_underrun (err_underrun),
    .error_output (error_output)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW:0] fill_of(input int ch);
    return fill[ch*(AW+1) +: (AW+1)];
  endfunction

  function automatic logic [BW-1:0] data_of(input int ch);
    return rd_data[ch*BW +: BW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int vc, input logic [BW-1:0] d);
    wr_en = 1'b1; wr_vc = CW'(vc); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input int vc, input logic [BW-1:0] exp, input string tag);
    rd_en = '0; rd_en[vc] = 1'b1;
    step();
    rd_en = '0;
    chk({tag, "_valid"}, 32'(rd_valid[vc]), 32'd1);
    chk({tag, "_data"}, 32'(data_of(vc)), 32'(exp));
  endtask

  initial begin
    reset_L = 1'b0; wr_en = 1'b0; wr_vc = '0; wr_data = '0; rd_en = '0;
    umbral_bajo = 4'd2; umbral_alto = 4'd6; err_clr = 1'b0;
    repeat (2) step();
    chk("rst_empty", 32'(empty), 32'hF);
    chk("rst_aempty", 32'(almost_empty), 32'hF);
    chk("rst_fill", 32'(fill), 32'h0);
    chk("rst_full_af", 32'({full, almost_full}), 32'h0);
    chk("rst_rdvalid", 32'(rd_valid), 32'h0);
    @(negedge clk) reset_L = 1'b1;
    step();
    chk("idle_empty", 32'(empty), 32'hF);
    chk("idle_pause", 32'(pause), 32'h0);
    chk("idle_err", 32'(error_output), 32'h0);

    // VC2: fill, overrun, drain in order
    for (int k = 1; k <= 8; k++) wr(2, BW'(k));
    chk("vc2_full", 32'(full[2]), 32'd1);
    chk("vc2_fill8", 32'(fill_of(2)), 32'd8);
    chk("vc2_noovr", 32'(err_overrun[2]), 32'd0);
    wr(2, 6'h09);
    chk("vc2_ovr", 32'(err_overrun[2]), 32'd1);
    chk("vc2_fill_after_ovr", 32'(fill_of(2)), 32'd8);
    chk("vc2_errout", 32'(error_output), 32'd1);
    for (int k = 1; k <= 8; k++) rd(2, BW'(k), "vc2_rd");
    step();
    chk("vc2_valid_drop", 32'(rd_valid[2]), 32'd0);
    chk("vc2_empty", 32'(empty[2]), 32'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("clr_errout", 32'(error_output), 32'd0);

    // VC1: pointer wrap
    for (int k = 0; k < 5; k++) wr(1, BW'(6'h10 + k));
    for (int k = 0; k < 5; k++) rd(1, BW'(6'h10 + k), "vc1_rdA");
    for (int k = 0; k < 8; k++) wr(1, BW'(6'h20 + k));
    chk("vc1_fill8", 32'(fill_of(1)), 32'd8);
    for (int k = 0; k < 8; k++) rd(1, BW'(6'h20 + k), "vc1_rdB");
    chk("vc1_fill0", 32'(fill_of(1)), 32'd0);

    // VC0: pause hysteresis
    for (int k = 0; k < 5; k++) wr(0, BW'(6'h30 + k));
    chk("vc0_pause5", 32'(pause[0]), 32'd0);
    wr(0, 6'h35);
    chk("vc0_pause6", 32'(pause[0]), 32'd1);
    chk("vc0_afull6", 32'(almost_full[0]), 32'd1);
    for (int k = 0; k < 3; k++) rd(0, BW'(6'h30 + k), "vc0_rd");
    chk("vc0_fill3", 32'(fill_of(0)), 32'd3);
    chk("vc0_pause3", 32'(pause[0]), 32'd1);
    rd(0, 6'h33, "vc0_rd");
    chk("vc0_pause2", 32'(pause[0]), 32'd0);
    chk("vc0_aempty2", 32'(almost_empty[0]), 32'd1);
    rd(0, 6'h34, "vc0_rd");
    rd(0, 6'h35, "vc0_rd");

    // VC3: simultaneous write+read when full, then when empty
    for (int k = 1; k <= 8; k++) wr(3, BW'(6'h2A + k));
    wr_en = 1'b1; wr_vc = 2'd3; wr_data = 6'h3F; rd_en = 4'b1000;
    step();
    wr_en = 1'b0; rd_en = '0;
    chk("vc3_full_wr_rd_fill", 32'(fill_of(3)), 32'd8);
    chk("vc3_full_wr_rd_ovr", 32'(err_overrun[3]), 32'd0);
    chk("vc3_full_wr_rd_data", 32'(data_of(3)), 32'h2B);
    for (int k = 2; k <= 8; k++) rd(3, BW'(6'h2A + k), "vc3_rd");
    rd(3, 6'h3F, "vc3_rd_last");
    chk("vc3_errout_clean", 32'(error_output), 32'd0);
    wr_en = 1'b1; wr_vc = 2'd3; wr_data = 6'h15; rd_en = 4'b1000;
    step();
    wr_en = 1'b0; rd_en = '0;
    chk("vc3_empty_unr", 32'(err_underrun[3]), 32'd1);
    chk("vc3_empty_fill", 32'(fill_of(3)), 32'd1);
    chk("vc3_empty_valid", 32'(rd_valid[3]), 32'd0);
    chk("vc3_empty_hold", 32'(data_of(3)), 32'h3F);
    rd(3, 6'h15, "vc3_rd_one");

    // clear coinciding with a fresh underrun keeps the bit
    err_clr = 1'b1; rd_en = 4'b1000;
    step();
    err_clr = 1'b0; rd_en = '0;
    chk("clr_vs_unr", 32'(err_underrun[3]), 32'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("clr_final", 32'(error_output), 32'd0);

    // reset in the middle of a burst
    for (int k = 0; k < 3; k++) wr(0, BW'(k + 1));
    wr_en = 1'b1; wr_vc = 2'd0; wr_data = 6'h07; rd_en = 4'b0001;
    step();
    chk("burst_valid", 32'(rd_valid[0]), 32'd1);
    chk("burst_fill", 32'(fill_of(0)), 32'd3);
    #2 reset_L = 1'b0;
    #1;
    chk("midrst_fill", 32'(fill), 32'h0);
    chk("midrst_valid", 32'(rd_valid), 32'h0);
    chk("midrst_empty", 32'(empty), 32'hF);
    wr_en = 1'b0; rd_en = '0;
    @(negedge clk) reset_L = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
